// File: rtl/fsm_stim_gen.sv
// ============================================================================
// Module   : fsm_stim_gen
// Function : Pattern-buffer symbol transmitter for the sequence-detector fsm
//            q1/q2 inputs, with repeat playback and a saturating tally of
//            cycles where the fsm reports count == 2'b11.
//            Optional macro FSM_GEN_ABORT_EN adds an abort input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_stim_gen #(
    parameter int DEPTH = 8,
    parameter int REP_W = 8,
    parameter int HIT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [1:0]       wr_sym,
    output logic             wr_ready,
    input  logic             clear,
    input  logic             start,
    input  logic [REP_W-1:0] rep_cnt,
    input  logic [1:0]       count,
`ifdef FSM_GEN_ABORT_EN
    input  logic             abort,
`endif
    output logic             q1,
    output logic             q2,
    output logic             busy,
    output logic             done,
    output logic [HIT_W-1:0] hit_cnt
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_PTR_W = c_IDX_W + 1;
    localparam logic [c_PTR_W-1:0] c_DEPTH = c_PTR_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_ONE   = c_PTR_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [1:0]         r_buf [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_IDX_W-1:0] r_cur;
    logic [c_IDX_W-1:0] w_cur_inc;
    logic [REP_W-1:0]   r_passes;
    logic [1:0]         r_sym;
    logic               r_busy;
    logic               r_done;
    logic [HIT_W-1:0]   r_hit;
    logic               w_wr_ready;
    logic               w_wr_en;
    logic               w_go;
    logic               w_last;
    logic               w_abort;

`ifdef FSM_GEN_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_cur_inc = r_cur + 1'b1;
    assign w_wr_en   = wr_valid && w_wr_ready;

    // r_cur indexes the symbol currently presented on q1/q2
    always_comb begin
        w_state_nxt = r_state;
        w_wr_ready  = 1'b0;
        w_go        = 1'b0;
        w_last      = ({1'b0, r_cur} == (r_wr_ptr - c_ONE));
        case (r_state)
            S_IDLE: begin
                w_wr_ready = (r_wr_ptr < c_DEPTH) && !start && !clear;
                if (start && !clear && (r_wr_ptr != '0)) begin
                    w_go        = 1'b1;
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (w_abort || (w_last && (r_passes == '0))) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            r_buf[r_wr_ptr[c_IDX_W-1:0]] <= wr_sym;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_cur    <= '0;
            r_passes <= '0;
            r_sym    <= 2'b00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hit    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (r_busy && (count == 2'b11) && (r_hit != '1)) begin
                r_hit <= r_hit + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_wr_ptr <= '0;
                    end else if (w_wr_en) begin
                        r_wr_ptr <= r_wr_ptr + c_ONE;
                    end
                    if (w_go) begin
                        r_sym    <= r_buf[0];
                        r_busy   <= 1'b1;
                        r_cur    <= '0;
                        r_passes <= rep_cnt;
                        r_hit    <= '0;
                    end
                end
                S_PLAY: begin
                    if (w_state_nxt == S_DONE) begin
                        r_sym  <= 2'b00;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else if (w_last) begin
                        r_cur    <= '0;
                        r_sym    <= r_buf[0];
                        r_passes <= r_passes - 1'b1;
                    end else begin
                        r_cur <= w_cur_inc;
                        r_sym <= r_buf[w_cur_inc];
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_ready = w_wr_ready;
    assign q1       = r_sym[1];
    assign q2       = r_sym[0];
    assign busy     = r_busy;
    assign done     = r_done;
    assign hit_cnt  = r_hit;

endmodule

`default_nettype wire

// File: doc/fsm_stim_gen.md
Name: fsm_stim_gen

Overview:
Programmable symbol transmitter that drives the q1/q2 inputs of the sequence-detector fsm from a loaded pattern buffer, replaying it a set number of times. It also watches the fsm's count output and tallies cycles where count == 2'b11 during playback. It is the driving end of the q1/q2 interface and replaces ad-hoc random stimulus in the fsm benches and on-chip self-test.

Parameters:
DEPTH, 8, pattern buffer entries (2-bit symbols); power of two, >= 2
REP_W, 8, width of repeat-count input
HIT_W, 16, width of hit counter

Ports:
clk  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high reset
wr_valid  in  1  pattern-load request
wr_sym  in  2  symbol to load, {q1,q2}
wr_ready  out  1  load accepted when wr_valid && wr_ready at posedge
clear  in  1  empties pattern buffer (IDLE only)
start  in  1  begin playback (IDLE only)
rep_cnt  in  REP_W  extra passes; total passes = rep_cnt+1, sampled on start
count  in  2  fsm count output being monitored
q1  out  1  symbol bit 1 to fsm, registered
q2  out  1  symbol bit 0 to fsm, registered
busy  out  1  high exactly while a pattern symbol is on q1/q2
done  out  1  one-cycle pulse after the last symbol
hit_cnt  out  HIT_W  playback cycles with count == 2'b11, saturating

Behaviour:
- Reset (sync): state IDLE, wr_ptr=0 (len=0), q1=q2=0, busy=0, done=0, hit_cnt=0; buffer contents don't-care. Reset mid-playback aborts immediately with the same values.
- States: IDLE, PLAY, DONE.
- IDLE: wr_ready = (wr_ptr < DEPTH) && !start && !clear. Accepted write stores wr_sym at buf[wr_ptr], wr_ptr+1. Full (wr_ptr==DEPTH): wr_ready=0, writes dropped. clear: wr_ptr<=0; clear wins over start in the same cycle. start with len==0 ignored (stays IDLE, no done).
- IDLE->PLAY on start && len>0: at that edge q1/q2 <= buf[0], busy<=1, rd_ptr<=1 (or 0 if len==1), passes_left<=rep_cnt, hit_cnt<=0. First symbol is visible the cycle after start is sampled.
- PLAY: each edge drives the next symbol. When the current symbol is index len-1: if passes_left>0, wrap rd_ptr to 0 and decrement passes_left; else go to DONE. Exactly len*(rep_cnt+1) consecutive busy cycles, no gaps between passes.
- PLAY->DONE edge: q1=q2=0, busy=0, done=1 for one cycle; DONE->IDLE next edge, done=0. Buffer and len are retained, so start may replay without reloading.
- start, wr_valid, clear while not IDLE: ignored.
- Hit count: at each posedge with busy==1 and count==2'b11, hit_cnt+1, saturating at all-ones. Held after playback until the next start or reset.
- Idle symbol outside playback is 2'b00.

Optional Feature:
FSM_GEN_ABORT_EN: adds input abort (1 bit). If abort==1 at a posedge in PLAY, the next state is DONE: q1/q2=00, busy=0, done pulses one cycle, hit_cnt keeps its value (including that edge's hit). abort is ignored in IDLE/DONE and has priority over wrap and last-symbol handling. Without the macro the port does not exist and playback always runs to completion.

Test Plan:
- Reset, load 01,10,11 (3 writes), start with rep_cnt=0 -> q1q2 = 01,10,11 on the 3 cycles after start, busy high 3 cycles, done pulse next cycle, q1q2=00.
- Same pattern, rep_cnt=2 -> 9 consecutive busy cycles repeating 01,10,11 with no gap; one done pulse.
- Write 10 symbols with DEPTH=8 -> wr_ready low after 8 accepts, last 2 dropped; playback length 8.
- Drive count=11 on 4 of 6 busy cycles -> hit_cnt=4 after done; new start clears it to 0.
- start with empty buffer, then clear+start in same cycle after load -> no busy, no done, len=0; start during PLAY ignored.
- Assert reset in the 2nd playback cycle -> next cycle busy=0, q1q2=00, hit_cnt=0, wr_ready=1.
